cva6_tlb_sv32: RTL and testbench
================================

Name: cva6_tlb_sv32

Overview:
- Fully associative Sv32 translation lookaside buffer for the CVA6 MMU (one instance per ITLB/DTLB).
- Combinational lookup of a 32-bit virtual address plus ASID returns the cached leaf PTE, a hit flag and a 4 MiB-superpage flag.
- Entries are written from the page-table walker via update_i and invalidated by SFENCE.VMA-style flushes.
- Replacement uses the first invalid entry, otherwise tree pseudo-LRU.

Parameters:
- TLB_ENTRIES, 4, number of entries; power of two, at least 2.
- ASID_WIDTH, 1, stored/compared ASID bits; the low ASID_WIDTH bits of the 9-bit update ASID are used.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  flush request, single cycle.
- update_i  in  63  packed {valid[62], is_4M[61], vpn[60:41], asid[40:32], content[31:0]}.
- lu_access_i  in  1  lookup is a real access; qualifies the PLRU update.
- lu_asid_i  in  ASID_WIDTH  lookup ASID.
- lu_vaddr_i  in  32  lookup virtual address; vpn1=[31:22], vpn0=[21:12].
- lu_content_o  out  32  Sv32 PTE of the hit entry: ppn[31:10], rsw[9:8], d,a,g,u,x,w,r,v [7:0].
- asid_to_be_flushed_i  in  ASID_WIDTH  flush ASID; 0 means all ASIDs.
- vaddr_to_be_flushed_i  in  32  flush address; 0 means all addresses.
- lu_is_4M_o  out  1  hit entry is a 4 MiB superpage.
- lu_hit_o  out  1  lookup hit.

Behaviour:
- Per-entry state: tag {valid, is_4M, vpn1[9:0], vpn0[9:0], asid[ASID_WIDTH-1:0]} and content[31:0].
- Reset: all valid=0, tags and content=0, PLRU bits=0. With every entry invalid the outputs read lu_hit_o=0, lu_is_4M_o=0, lu_content_o=0.
- Lookup is purely combinational, zero latency. Entry i matches when all of these hold:
  - valid
  - (asid == lu_asid_i) or content.g (bit 5)
  - vpn1 == lu_vaddr_i[31:22]
  - is_4M or vpn0 == lu_vaddr_i[21:12]
- Outputs on a hit: lu_hit_o is the OR of all matches. lu_content_o and lu_is_4M_o come from the lowest-index matching entry; with no hit both are 0.
- A lookup in the same cycle as an update or flush sees the pre-edge state.
- Flush (flush_i=1), applied at the clock edge:
  - asid==0 and vaddr==0: clear valid on all entries.
  - asid==0 and vaddr!=0: clear entries whose vpn1 matches vaddr[31:22] and (is_4M or vpn0 matches vaddr[21:12]).
  - asid!=0 and vaddr==0: clear entries with asid match and g==0.
  - both nonzero: clear entries with address match, asid match and g==0.
- Update (update_i[62]=1 and flush_i=0): write tag and content into the replacement entry and set valid.
  - Replacement entry: lowest-index invalid entry if one exists, else the PLRU victim.
  - Duplicate tags are not checked; lookup priority resolves any duplicates.
- Flush has priority; an update in a flush cycle is dropped.
- PLRU: binary tree of TLB_ENTRIES-1 bits, node 0 is the root.
  - Victim walk: node bit 0 selects the left child, 1 the right.
  - When lu_hit_o and lu_access_i are both 1, set every node on the hit entry's path to point away from it.
  - PLRU bits do not change on update or flush.
- Reset asserted mid-operation clears all state immediately.

Decomposition:
- Shared package cva6_tlb_pkg holds:
  - tlb_update_sv32_t (63-bit packed struct)
  - pte_sv32_t
  - tlb_tag_sv32_t
  - field-position constants
- One sub-module, tlb_plru_tree: hit-index in, access strobe in, victim index out, holds the tree bits.

Test Plan:
- Reset -> lookup vaddr 0x0000A000, asid 1 -> lu_hit_o=0, lu_content_o=0, lu_is_4M_o=0.
- Update vpn=0x0000A, asid=1, content=0x12345601, is_4M=0; next cycle look up 0x0000A000 asid 1 -> hit=1, content=0x12345601, is_4M=0. Same lookup with asid 0 -> hit=0.
- Update with is_4M=1, vpn=0x80000, content 0x2000002F (g=1); look up 0x803FF000 asid 0 -> hit=1, is_4M=1, content=0x2000002F.
- Fill 5 distinct vpns with no lookups -> first 4 land in entries 0..3, the 5th replaces entry 0 (PLRU=0). Repeat with a lookup hit on entry 0 (lu_access_i=1) before the 5th update -> entry 2 is replaced.
- Flush with asid=0, vaddr=0 -> all entries miss next cycle. Flush with asid=1, vaddr=0x0000A000 -> only the non-global matching entry is removed; a global entry at the same vpn survives.
- flush_i=1 with a valid update in the same cycle -> no entry written. Lookup during an update cycle -> returns the pre-update result.

Source files
------------

// File: rtl/cva6_tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cva6_tlb_pkg
// Description : Shared types and field positions for the Sv32 TLB. It holds
//               the update packet from the page-table walker, the Sv32 leaf
//               PTE layout and the per-entry tag layout.
// Revision    : 1.0 - initial release
// ============================================================================
package cva6_tlb_pkg;

  localparam int unsigned VPN_WIDTH       = 20;
  localparam int unsigned VPN_PART_WIDTH  = 10;
  localparam int unsigned ASID_FULL_WIDTH = 9;
  localparam int unsigned VADDR_VPN1_LSB  = 22;
  localparam int unsigned VADDR_VPN0_LSB  = 12;
  localparam int unsigned PTE_G_BIT       = 5;
  localparam int unsigned UPD_VALID_BIT   = 62;
  localparam int unsigned UPD_IS_4M_BIT   = 61;
  localparam int unsigned UPD_VPN_LSB     = 41;
  localparam int unsigned UPD_ASID_LSB    = 32;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv32_t;

  typedef struct packed {
    logic                       valid;
    logic                       is_4M;
    logic [VPN_WIDTH-1:0]       vpn;
    logic [ASID_FULL_WIDTH-1:0] asid;
    pte_sv32_t                  content;
  } tlb_update_sv32_t;

  // The ASID is kept outside the tag because its stored width is a module
  // parameter, which a package struct cannot depend on.
  typedef struct packed {
    logic                      valid;
    logic                      is_4M;
    logic [VPN_PART_WIDTH-1:0] vpn1;
    logic [VPN_PART_WIDTH-1:0] vpn0;
  } tlb_tag_sv32_t;

  // Address part of a match: vpn0 is ignored for 4 MiB superpages.
  function automatic logic tag_addr_match(tlb_tag_sv32_t tag, logic [VPN_WIDTH-1:0] vpn);
    return (tag.vpn1 == vpn[19:10]) && (tag.is_4M || (tag.vpn0 == vpn[9:0]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cva6_tlb_sv32_plru.sv
`default_nettype none
// ============================================================================
// Module      : tlb_plru_tree
// Description : Tree pseudo-LRU state for a fully associative TLB.
//               Node 0 is the root; node n has children 2n+1 (left) and
//               2n+2 (right). A node bit of 0 points the victim walk left.
// Ports       : clk_i        - clock
//               rst_ni       - asynchronous active-low reset
//               access_i     - qualified hit strobe (hit and real access)
//               hit_idx_i    - entry that was hit
//               victim_idx_o - entry currently selected for replacement
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_plru_tree #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       access_i,
  input  logic [$clog2(ENTRIES)-1:0] hit_idx_i,
  output logic [$clog2(ENTRIES)-1:0] victim_idx_o
);

  localparam int unsigned LEVELS = $clog2(ENTRIES);
  localparam int unsigned NODES  = ENTRIES - 1;

  logic [NODES-1:0]   tree_q;
  logic [NODES-1:0]   tree_d;
  logic [ENTRIES-1:0] leaf_sel;

  // A node lies on the hit path when the hit index's prefix above its level
  // equals the node's position within that level. On a hit it is set to
  // point to the opposite child from the one the path descends into.
  generate
    for (genvar n = 0; n < NODES; n++) begin : g_node
      localparam int unsigned LVL = $clog2(n + 2) - 1;
      localparam int unsigned OFF = n - (2 ** LVL - 1);
      logic on_path;
      assign on_path   = (hit_idx_i >> (LEVELS - LVL)) == LEVELS'(OFF);
      assign tree_d[n] = (access_i && on_path) ? ~hit_idx_i[LEVELS-1-LVL] : tree_q[n];
    end
  endgenerate

  // Each leaf checks that every node on its path steers towards it; exactly
  // one leaf satisfies this for any tree state.
  generate
    for (genvar e = 0; e < ENTRIES; e++) begin : g_leaf
      logic [LEVELS-1:0] steps;
      for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int unsigned NODE = (2 ** l - 1) + (e >> (LEVELS - l));
        localparam int unsigned DIR  = (e >> (LEVELS - 1 - l)) & 1;
        assign steps[l] = (tree_q[NODE] == 1'(DIR));
      end
      assign leaf_sel[e] = &steps;
    end
  endgenerate

  always_comb begin
    victim_idx_o = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (leaf_sel[e]) victim_idx_o = LEVELS'(e);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tree_q <= '0;
    else         tree_q <= tree_d;
  end

endmodule
`default_nettype wire

// File: rtl/cva6_tlb_sv32.sv
`default_nettype none
// ============================================================================
// Module      : cva6_tlb_sv32
// Description : Fully associative Sv32 TLB with combinational lookup,
//               SFENCE.VMA-style flush and first-invalid / tree-PLRU
//               replacement.
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               flush_i                - flush request (single cycle)
//               asid_to_be_flushed_i   - flush ASID, 0 = all ASIDs
//               vaddr_to_be_flushed_i  - flush address, 0 = all addresses
//               update_i               - walker write {valid,is_4M,vpn,asid,pte}
//               lu_access_i            - lookup is a real access (PLRU touch)
//               lu_asid_i, lu_vaddr_i  - lookup key
//               lu_content_o           - PTE of lowest-index matching entry
//               lu_is_4M_o, lu_hit_o   - superpage flag, hit flag
// Revision    : 1.0 - initial release
// ============================================================================
module cva6_tlb_sv32
  import cva6_tlb_pkg::*;
#(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [62:0]           update_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [31:0]           lu_vaddr_i,
  output logic [31:0]           lu_content_o,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [31:0]           vaddr_to_be_flushed_i,
  output logic                  lu_is_4M_o,
  output logic                  lu_hit_o
);

  localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

  tlb_update_sv32_t      upd;
  tlb_tag_sv32_t         tags     [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0] asids    [TLB_ENTRIES];
  pte_sv32_t             contents [TLB_ENTRIES];

  logic [TLB_ENTRIES-1:0] lu_match;
  logic [TLB_ENTRIES-1:0] flush_clr;
  logic [IDX_W-1:0]       hit_idx;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       plru_victim;
  logic [IDX_W-1:0]       repl_idx;
  logic                   any_invalid;
  logic                   flush_all_asid;
  logic                   flush_all_addr;

  assign upd            = update_i;
  assign flush_all_asid = (asid_to_be_flushed_i == '0);
  assign flush_all_addr = (vaddr_to_be_flushed_i == '0);

  generate
    for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_entry
      logic lu_asid_ok;
      logic fl_addr_hit;
      logic fl_asid_hit;
      // Global mappings match every ASID on lookup but are exempt from
      // ASID-qualified flushes.
      assign lu_asid_ok  = (asids[i] == lu_asid_i) || contents[i].g;
      assign lu_match[i] = tags[i].valid && lu_asid_ok &&
                           tag_addr_match(tags[i], lu_vaddr_i[31:12]);
      assign fl_addr_hit = tag_addr_match(tags[i], vaddr_to_be_flushed_i[31:12]);
      assign fl_asid_hit = (asids[i] == asid_to_be_flushed_i) && !contents[i].g;
      assign flush_clr[i] = flush_all_asid ? (flush_all_addr || fl_addr_hit)
                                           : (fl_asid_hit && (flush_all_addr || fl_addr_hit));
    end
  endgenerate

  // Lowest-index match wins; the descending loop leaves it as the final value.
  always_comb begin
    hit_idx      = '0;
    lu_content_o = '0;
    lu_is_4M_o   = 1'b0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (lu_match[i]) begin
        hit_idx      = IDX_W'(i);
        lu_content_o = contents[i];
        lu_is_4M_o   = tags[i].is_4M;
      end
    end
  end

  assign lu_hit_o = |lu_match;

  always_comb begin
    any_invalid = 1'b0;
    free_idx    = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!tags[i].valid) begin
        any_invalid = 1'b1;
        free_idx    = IDX_W'(i);
      end
    end
  end

  assign repl_idx = any_invalid ? free_idx : plru_victim;

  tlb_plru_tree #(
    .ENTRIES(TLB_ENTRIES)
  ) u_plru (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .access_i    (lu_hit_o && lu_access_i),
    .hit_idx_i   (hit_idx),
    .victim_idx_o(plru_victim)
  );

  // Flush takes priority: an update presented in a flush cycle is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tags[i]     <= '0;
        asids[i]    <= '0;
        contents[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        if (flush_clr[i]) tags[i].valid <= 1'b0;
      end
    end else if (upd.valid) begin
      tags[repl_idx]     <= '{valid: 1'b1, is_4M: upd.is_4M,
                              vpn1: upd.vpn[19:10], vpn0: upd.vpn[9:0]};
      asids[repl_idx]    <= upd.asid[ASID_WIDTH-1:0];
      contents[repl_idx] <= upd.content;
    end
  end

  // Page-offset bits of the lookup address never take part in translation.
  logic unused_lu_offset;
  assign unused_lu_offset = ^lu_vaddr_i[11:0];

  generate
    if (ASID_WIDTH < ASID_FULL_WIDTH) begin : g_asid_trunc
      logic unused_upd_asid;
      assign unused_upd_asid = ^upd.asid[ASID_FULL_WIDTH-1:ASID_WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cva6_tlb_sv32.sv
`default_nettype none
// ============================================================================
// Module      : tb_cva6_tlb_sv32
// Description : Self-checking bench for cva6_tlb_sv32: directed scenarios
//               plus randomized traffic compared against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cva6_tlb_sv32;

  localparam int E  = 4;
  localparam int AW = 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [62:0]   update;
  logic          access;
  logic [AW-1:0] lu_asid;
  logic [31:0]   lu_vaddr;
  logic [31:0]   lu_content;
  logic [AW-1:0] fl_asid;
  logic [31:0]   fl_vaddr;
  logic          lu_is4m;
  logic          lu_hit;

  int checks = 0;
  int passed = 0;

  // Reference model state.
  logic          m_valid   [E];
  logic          m_is4m    [E];
  logic [19:0]   m_vpn     [E];
  logic [AW-1:0] m_asid    [E];
  logic [31:0]   m_content [E];
  logic          m_plru    [E-1];

  cva6_tlb_sv32 #(.TLB_ENTRIES(E), .ASID_WIDTH(AW)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .flush_i              (flush),
    .update_i             (update),
    .lu_access_i          (access),
    .lu_asid_i            (lu_asid),
    .lu_vaddr_i           (lu_vaddr),
    .lu_content_o         (lu_content),
    .asid_to_be_flushed_i (fl_asid),
    .vaddr_to_be_flushed_i(fl_vaddr),
    .lu_is_4M_o           (lu_is4m),
    .lu_hit_o             (lu_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [62:0] mk_upd(input logic is4m, input logic [19:0] vpn,
                                         input logic [8:0] asid, input logic [31:0] content);
    return {1'b1, is4m, vpn, asid, content};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < E; i++) begin
      m_valid[i] = 1'b0; m_is4m[i] = 1'b0; m_vpn[i] = '0; m_asid[i] = '0; m_content[i] = '0;
    end
    for (int i = 0; i < E - 1; i++) m_plru[i] = 1'b0;
  endfunction

  function automatic logic model_addr(input int i, input logic [31:0] va);
    return (m_vpn[i][19:10] == va[31:22]) && (m_is4m[i] || m_vpn[i][9:0] == va[21:12]);
  endfunction

  function automatic void model_lookup(input logic [31:0] va, input logic [AW-1:0] as,
                                       output logic hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < E; i++) begin
      if (!hit && m_valid[i] && (m_asid[i] == as || m_content[i][5]) && model_addr(i, va)) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endfunction

  // Walk down from the root: each node value picks the child to descend to.
  function automatic int model_victim();
    int n = 0;
    while (n < E - 1) n = 2 * n + 1 + (m_plru[n] ? 1 : 0);
    return n - (E - 1);
  endfunction

  // Walk up from the leaf, pointing each parent at the sibling subtree.
  function automatic void model_touch(input int idx);
    int n = idx + E - 1;
    int p;
    while (n > 0) begin
      p = (n - 1) / 2;
      m_plru[p] = (n == 2 * p + 1);
      n = p;
    end
  endfunction

  function automatic void model_edge();
    logic h;
    int   hi;
    int   slot;
    logic clr;
    logic am;
    logic sm;
    model_lookup(lu_vaddr, lu_asid, h, hi);
    if (flush) begin
      for (int i = 0; i < E; i++) begin
        am = model_addr(i, fl_vaddr);
        sm = (m_asid[i] == fl_asid) && !m_content[i][5];
        if (fl_asid == '0 && fl_vaddr == '0) clr = 1'b1;
        else if (fl_asid == '0)              clr = am;
        else if (fl_vaddr == '0)             clr = sm;
        else                                 clr = am && sm;
        if (clr) m_valid[i] = 1'b0;
      end
    end else if (update[62]) begin
      slot = -1;
      for (int i = 0; i < E; i++) if (slot < 0 && !m_valid[i]) slot = i;
      if (slot < 0) slot = model_victim();
      m_valid[slot]   = 1'b1;
      m_is4m[slot]    = update[61];
      m_vpn[slot]     = update[60:41];
      m_asid[slot]    = update[32 +: AW];
      m_content[slot] = update[31:0];
    end
    if (h && access) model_touch(hi);
  endfunction

  task automatic apply(input logic fl, input logic [AW-1:0] fa, input logic [31:0] fv,
                       input logic [62:0] up, input logic acc,
                       input logic [AW-1:0] la, input logic [31:0] lv);
    @(negedge clk);
    flush = fl; fl_asid = fa; fl_vaddr = fv; update = up; access = acc;
    lu_asid = la; lu_vaddr = lv;
    #1;
  endtask

  task automatic lookup(input logic [AW-1:0] la, input logic [31:0] lv);
    apply(1'b0, '0, '0, '0, 1'b0, la, lv);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    flush = 1'b0; update = '0; access = 1'b0; lu_asid = '0; lu_vaddr = '0;
    fl_asid = '0; fl_vaddr = '0;
    rst_n = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    lookup(1'b1, 32'h0000_A000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", lu_hit); else passed++;
    checks++; if (lu_content !== 32'h0) $display("FAIL reset_content: got %h want 00000000", lu_content); else passed++;
    checks++; if (lu_is4m !== 1'b0) $display("FAIL reset_is4m: got %b want 0", lu_is4m); else passed++;
    tick();
    // Reset asserted between edges must clear state without waiting for a clock.
    apply(1'b0, '0, '0, mk_upd(1'b0, 20'h0000A, 9'd1, 32'h1234_5601), 1'b0, 1'b1, 32'h0000_A000);
    tick();
    lookup(1'b1, 32'h0000_A000);
    checks++; if (lu_hit !== 1'b1) $display("FAIL pre_async_reset_hit: got %b want 1", lu_hit); else passed++;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (lu_hit !== 1'b0) $display("FAIL async_reset_hit: got %b want 0", lu_hit); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    // Lookup in the update cycle sees the pre-update (empty) state.
    apply(1'b0, '0, '0, mk_upd(1'b0, 20'h0000A, 9'd1, 32'h1234_5601), 1'b0, 1'b1, 32'h0000_A000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL same_cycle_lookup: got %b want 0", lu_hit); else passed++;
    tick();
    lookup(1'b1, 32'h0000_A000);
    checks++; if (lu_hit !== 1'b1) $display("FAIL basic_hit: got %b want 1", lu_hit); else passed++;
    checks++; if (lu_content !== 32'h1234_5601) $display("FAIL basic_content: got %h want 12345601", lu_content); else passed++;
    checks++; if (lu_is4m !== 1'b0) $display("FAIL basic_is4m: got %b want 0", lu_is4m); else passed++;
    tick();
    lookup(1'b0, 32'h0000_A000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL basic_wrong_asid: got %b want 0", lu_hit); else passed++;
    tick();
  endtask

  task automatic test_superpage();
    apply(1'b0, '0, '0, mk_upd(1'b1, 20'h80000, 9'd0, 32'h2000_002F), 1'b0, 1'b0, 32'h0);
    tick();
    lookup(1'b0, 32'h803F_F000);
    checks++; if (lu_hit !== 1'b1) $display("FAIL super_hit: got %b want 1", lu_hit); else passed++;
    checks++; if (lu_is4m !== 1'b1) $display("FAIL super_is4m: got %b want 1", lu_is4m); else passed++;
    checks++; if (lu_content !== 32'h2000_002F) $display("FAIL super_content: got %h want 2000002f", lu_content); else passed++;
    tick();
  endtask

  task automatic test_replacement();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, '0, '0, mk_upd(1'b0, 20'h10 + 20'(k), 9'd1, 32'hC0DE_0001 + 32'(k << 8)), 1'b0, 1'b0, 32'h0);
      tick();
    end
    lookup(1'b1, 32'h0001_0000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL repl_entry0_evicted: got %b want 0", lu_hit); else passed++;
    tick();
    lookup(1'b1, 32'h0001_4000);
    checks++; if (lu_content !== 32'hC0DE_0401) $display("FAIL repl_fifth_content: got %h want c0de0401", lu_content); else passed++;
    tick();
    lookup(1'b1, 32'h0001_2000);
    checks++; if (lu_hit !== 1'b1) $display("FAIL repl_entry2_kept: got %b want 1", lu_hit); else passed++;
    tick();

    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, '0, '0, mk_upd(1'b0, 20'h10 + 20'(k), 9'd1, 32'hC0DE_0001 + 32'(k << 8)), 1'b0, 1'b0, 32'h0);
      tick();
    end
    apply(1'b0, '0, '0, '0, 1'b1, 1'b1, 32'h0001_0000);
    checks++; if (lu_hit !== 1'b1) $display("FAIL repl_touch_hit: got %b want 1", lu_hit); else passed++;
    tick();
    apply(1'b0, '0, '0, mk_upd(1'b0, 20'h14, 9'd1, 32'hC0DE_0401), 1'b0, 1'b0, 32'h0);
    tick();
    lookup(1'b1, 32'h0001_2000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL repl_plru_entry2_evicted: got %b want 0", lu_hit); else passed++;
    tick();
    lookup(1'b1, 32'h0001_0000);
    checks++; if (lu_content !== 32'hC0DE_0001) $display("FAIL repl_plru_entry0_kept: got %h want c0de0001", lu_content); else passed++;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    apply(1'b0, '0, '0, mk_upd(1'b0, 20'h0000A, 9'd1, 32'h1111_1101), 1'b0, 1'b0, 32'h0);
    tick();
    apply(1'b0, '0, '0, mk_upd(1'b0, 20'h0000A, 9'd1, 32'h2222_2221), 1'b0, 1'b0, 32'h0);
    tick();
    apply(1'b0, '0, '0, mk_upd(1'b0, 20'h0000B, 9'd0, 32'h3333_3301), 1'b0, 1'b0, 32'h0);
    tick();
    lookup(1'b1, 32'h0000_A000);
    checks++; if (lu_content !== 32'h1111_1101) $display("FAIL flush_pre_priority: got %h want 11111101", lu_content); else passed++;
    tick();
    apply(1'b1, 1'b1, 32'h0000_A000, '0, 1'b0, 1'b0, 32'h0);
    tick();
    lookup(1'b1, 32'h0000_A000);
    checks++; if (lu_content !== 32'h2222_2221) $display("FAIL flush_global_survives: got %h want 22222221", lu_content); else passed++;
    tick();
    lookup(1'b0, 32'h0000_B000);
    checks++; if (lu_hit !== 1'b1) $display("FAIL flush_other_vpn_kept: got %b want 1", lu_hit); else passed++;
    tick();
    apply(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
    tick();
    lookup(1'b1, 32'h0000_A000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL flush_all_a: got %b want 0", lu_hit); else passed++;
    tick();
    lookup(1'b0, 32'h0000_B000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL flush_all_b: got %b want 0", lu_hit); else passed++;
    tick();
  endtask

  task automatic test_flush_update_conflict();
    do_reset();
    apply(1'b1, 1'b1, 32'h00FF_F000, mk_upd(1'b0, 20'h00033, 9'd1, 32'h4444_4401), 1'b0, 1'b0, 32'h0);
    tick();
    lookup(1'b1, 32'h0003_3000);
    checks++; if (lu_hit !== 1'b0) $display("FAIL flush_drops_update: got %b want 0", lu_hit); else passed++;
    tick();
  endtask

  task automatic test_random();
    logic [9:0]  vpn1_pool [3];
    logic [9:0]  vpn0_pool [3];
    logic        fl;
    logic [62:0] up;
    logic [31:0] fv;
    logic [31:0] lv;
    logic        exp_hit;
    int          exp_idx;
    vpn1_pool[0] = 10'h001; vpn1_pool[1] = 10'h002; vpn1_pool[2] = 10'h200;
    vpn0_pool[0] = 10'h000; vpn0_pool[1] = 10'h00A; vpn0_pool[2] = 10'h3FF;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fl = ($urandom_range(0, 11) == 0);
      fv = ($urandom_range(0, 2) == 0) ? 32'h0 :
           {vpn1_pool[$urandom_range(0, 2)], vpn0_pool[$urandom_range(0, 2)], 12'($urandom)};
      up = '0;
      if ($urandom_range(0, 2) == 0)
        up = mk_upd(1'($urandom), {vpn1_pool[$urandom_range(0, 2)], vpn0_pool[$urandom_range(0, 2)]},
                    9'($urandom), $urandom);
      lv = {vpn1_pool[$urandom_range(0, 2)], vpn0_pool[$urandom_range(0, 2)], 12'($urandom)};
      apply(fl, AW'($urandom_range(0, 1)), fv, up, 1'($urandom), AW'($urandom_range(0, 1)), lv);
      model_lookup(lu_vaddr, lu_asid, exp_hit, exp_idx);
      checks++; if (lu_hit !== exp_hit) $display("FAIL rand_hit cyc %0d: got %b want %b", c, lu_hit, exp_hit); else passed++;
      checks++;
      if (lu_content !== (exp_hit ? m_content[exp_idx] : 32'h0))
        $display("FAIL rand_content cyc %0d: got %h want %h", c, lu_content, exp_hit ? m_content[exp_idx] : 32'h0);
      else passed++;
      checks++;
      if (lu_is4m !== (exp_hit ? m_is4m[exp_idx] : 1'b0))
        $display("FAIL rand_is4m cyc %0d: got %b want %b", c, lu_is4m, exp_hit ? m_is4m[exp_idx] : 1'b0);
      else passed++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; update = '0; access = 1'b0;
    lu_asid = '0; lu_vaddr = '0; fl_asid = '0; fl_vaddr = '0;
    model_clear();
    test_reset();
    test_basic();
    test_superpage();
    test_replacement();
    test_flush();
    test_flush_update_conflict();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
